pcie_rd_buf_ctrl: RTL and testbench

PCIE_RD_BUF_CTRL -- requirements
Module: pcie_rd_buf_ctrl

---
 rtl/pcie_rd_buf_pkg.sv | 14 +
 rtl/pcie_rd_buf_skid.sv | 40 ++++
 rtl/pcie_rd_buf_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pcie_rd_buf_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rd_buf_pkg.sv
// Shared sizing defaults and read-FSM encoding for the PCIe read-data bank buffer.
package pcie_rd_buf_pkg;

  localparam int unsigned BANK_DEPTH = 256;
  localparam int unsigned DATA_W_DEF = 256;
  localparam int unsigned ADDR_W_DEF = $clog2(BANK_DEPTH) + 1;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pcie_rd_buf_skid.sv
// Two-entry output FIFO catching RAM read data one cycle after each read issue.
module pcie_rd_buf_skid #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   cnt
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_idx;
  logic              rd_idx;

  // Storage carries no reset; only the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_idx] <= push_data;
        wr_idx        <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign valid = (cnt != 2'd0);
  assign data  = mem_q[rd_idx];

endmodule

// File: rtl/pcie_rd_buf_ctrl.sv
// Ping-pong bank controller: frames land in one RAM bank while the other streams to PCIe.
module pcie_rd_buf_ctrl
  import pcie_rd_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        bank_full
);

  localparam int unsigned PW = ADDR_W - 1;
  localparam int unsigned LW = ADDR_W;

  logic                 clr;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [PW-1:0]        wr_ptr;
  logic [LW-1:0]        rd_ptr;
  logic [1:0][LW-1:0]   len_q;
  logic [1:0]           full_q;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic                 in_flight_q;
  logic                 in_flight_last_q;
  rd_state_e            state_q;
  rd_state_e            state_d;
  logic                 s_fire;
  logic                 close;
  logic [LW-1:0]        cur_len;
  logic [2:0]           occ;
  logic                 issue;
  logic                 issue_last;
  logic                 pop;
  logic                 last_pop;
  logic [1:0]           set_m;
  logic [1:0]           clr_m;
  logic                 fifo_valid;
  logic [DATA_W:0]      fifo_data;
  logic [1:0]           fifo_cnt;

  assign clr        = rst | buf_flush;
  assign s_fire     = s_valid & ~full_q[wr_bank];
  assign close      = s_fire & (s_last | (wr_ptr == {PW{1'b1}}));
  assign cur_len    = len_q[rd_bank];
  assign pop        = m_valid & m_ready;
  assign last_pop   = pop & fifo_data[DATA_W];
  assign occ        = 3'(fifo_cnt) + 3'(in_flight_q) - 3'(pop);
  assign issue      = (state_q == RD_STREAM) && (rd_ptr < cur_len) && (occ < 3'd2);
  assign issue_last = issue && (rd_ptr == cur_len - LW'(1));
  assign set_m      = {close & wr_bank, close & ~wr_bank};
  assign clr_m      = {last_pop & rd_bank, last_pop & ~rd_bank};

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state: wait for a full bank, issue its reads, then wait for the last beat out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (full_q[rd_bank]) state_d = RD_STREAM;
      RD_STREAM: if (issue_last)      state_d = RD_DRAIN;
      RD_DRAIN:  if (last_pop)        state_d = RD_IDLE;
      default:                        state_d = RD_IDLE;
    endcase
  end

  // Ingress: register each accepted beat to the RAM port and close the bank on last or wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_bank   <= 1'b0;
      wr_ptr    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
    end else begin
      wr_en_q <= s_fire;
      if (s_fire) begin
        wr_addr_q <= {wr_bank, wr_ptr};
        wr_data_q <= s_data;
      end
      if (close) begin
        len_q[wr_bank] <= LW'(wr_ptr) + LW'(1);
        wr_bank        <= ~wr_bank;
        wr_ptr         <= '0;
      end else if (s_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Bank flags: writer and reader always act on different banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (clr) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q | set_m) & ~clr_m;
    end
  end

  // Egress read pointer and the one-cycle RAM latency tracker.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_bank          <= 1'b0;
      rd_ptr           <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      in_flight_q      <= issue;
      in_flight_last_q <= issue_last;
      if ((state_q == RD_IDLE) && full_q[rd_bank]) begin
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      if (last_pop) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  pcie_rd_buf_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .clr       (clr),
    .push      (in_flight_q),
    .push_data ({in_flight_last_q, ram_rd_data}),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .cnt       (fifo_cnt)
  );

  assign s_ready     = rst | ~full_q[wr_bank];
  assign ram_wr_en   = wr_en_q & ~rst;
  assign ram_wr_addr = rst ? '0 : wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rst ? '0 : {rd_bank, rd_ptr[PW-1:0]};
  assign m_valid     = fifo_valid & ~rst;
  assign m_last      = m_valid & fifo_data[DATA_W];
  assign m_data      = fifo_data[DATA_W-1:0];
  assign bank_full   = full_q;

endmodule

// File: tb/tb_pcie_rd_buf_ctrl.sv
// Randomized bench for pcie_rd_buf_ctrl against a frame-queue reference model.
module tb_pcie_rd_buf_ctrl;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 9;
  localparam int          BANK   = 256;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              buf_flush = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b0;
  logic [1:0]        bank_full;

  int checks = 0;
  int errors = 0;
  int rmode  = 1;
  int cyc    = 0;

  // reference model state
  beat_t             exp_q[$];
  logic [DATA_W-1:0] cur_q[$];
  int                obs_len[$];
  logic [1:0]        m_full = 2'b00;
  int                m_wr_bank = 0;
  int                m_rd_bank = 0;
  int                m_wr_ptr = 0;
  int                pend = 0;
  int                pend_addr = 0;
  logic [DATA_W-1:0] pend_data = '0;
  int                wait_first = 0;
  int                t_close = 0;
  int                fbeats = 0;
  int                pop_cnt = 0;

  logic [DATA_W-1:0] mem [2*BANK];

  pcie_rd_buf_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_flush   (buf_flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .ram_wr_data (ram_wr_data),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .bank_full   (bank_full)
  );

  always #5 clk = ~clk;

  // external synchronous RAM, read data valid the cycle after the address edge
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur_q.delete();
    m_full = 2'b00;
    m_wr_bank = 0;
    m_rd_bank = 0;
    m_wr_ptr = 0;
    pend = 0;
    wait_first = 0;
    fbeats = 0;
  endtask

  // per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_wr_en", int'(ram_wr_en), 0);
      chk("rst_wr_addr", int'(ram_wr_addr), 0);
      chk("rst_rd_addr", int'(ram_rd_addr), 0);
      chk("rst_s_ready", int'(s_ready), 1);
    end else begin
      chk("s_ready", int'(s_ready), int'(!m_full[m_wr_bank]));
      chk("bank_full", int'(bank_full), int'(m_full));
      chk("wr_en", int'(ram_wr_en), pend);
      if (pend != 0) begin
        chk("wr_addr", int'(ram_wr_addr), pend_addr);
        chk_d("wr_data", ram_wr_data, pend_data);
      end
      chk("fifo_cnt_le2", int'(dut.u_skid.cnt <= 2'd2), 1);
      if (m_valid) begin
        if (wait_first != 0) begin
          chk("first_valid_latency", cyc - t_close, 4);
          wait_first = 0;
        end
        if (exp_q.size() == 0) begin
          chk("spurious_m_valid", int'(m_valid), 0);
        end else if (m_ready) begin
          b = exp_q.pop_front();
          chk_d("m_data", m_data, b.data);
          chk("m_last", int'(m_last), int'(b.last));
          pop_cnt++;
          fbeats++;
          if (b.last) begin
            obs_len.push_back(fbeats);
            fbeats = 0;
            m_full[m_rd_bank] = 1'b0;
            m_rd_bank ^= 1;
          end
        end
      end
    end
    pend = 0;
    if (s_valid && s_ready && !rst && !buf_flush) begin
      pend = 1;
      pend_addr = m_wr_bank * BANK + m_wr_ptr;
      pend_data = s_data;
      cur_q.push_back(s_data);
      if (s_last || m_wr_ptr == BANK - 1) begin
        if (exp_q.size() == 0) begin
          wait_first = 1;
          t_close = cyc;
        end
        for (int i = 0; i < cur_q.size(); i++) exp_q.push_back({(i == cur_q.size() - 1), cur_q[i]});
        cur_q.delete();
        m_full[m_wr_bank] = 1'b1;
        m_wr_bank ^= 1;
        m_wr_ptr = 0;
      end else begin
        m_wr_ptr++;
      end
    end
    if (rst || buf_flush) model_reset();
  end

  // egress backpressure patterns
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        2:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic last);
    int g = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      g++;
      if (g > 4000) begin
        checks++;
        errors++;
        $display("FAIL push_timeout t=%0t actual=s_ready_low required=accept", $time);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_frame(input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      push_beat(rnd_data(), i == n - 1);
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
      g++;
      if (g > 6000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout t=%0t actual=%0d_pending required=0", $time, exp_q.size());
        break;
      end
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    obs_len.delete();
  endtask

  initial begin
    int g;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;

    // full 256-beat frame, data = index, bank wraps on pointer 255
    rmode = 1;
    for (int i = 0; i < BANK; i++) push_beat(DATA_W'(i), 1'b0);
    chk("t1_bank_full", int'(bank_full), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_m_valid_cycle", int'(m_valid), int'(k == 4));
    end
    chk_d("t1_first_data", m_data, '0);
    @(posedge clk); #1;
    wait_drain();
    chk("t1_frame_len", (obs_len.size() > 0) ? obs_len[0] : -1, 256);

    // short frame closed by s_last, next frame opens bank 1
    do_reset();
    push_frame(5, 0);
    push_beat(rnd_data(), 1'b0);
    chk("t2_next_addr", int'(ram_wr_addr), 256);
    chk("t2_next_wr_en", int'(ram_wr_en), 1);
    push_beat(rnd_data(), 1'b0);
    push_beat(rnd_data(), 1'b1);
    wait_drain();
    chk("t2_frame_len", (obs_len.size() > 0) ? obs_len[0] : -1, 5);

    // toggling m_ready over a 20-beat frame
    do_reset();
    rmode = 2;
    push_frame(20, 0);
    wait_drain();
    chk("t3_frame_len", (obs_len.size() > 0) ? obs_len[0] : -1, 20);

    // both banks full under backpressure, then release bank 0
    do_reset();
    rmode = 0;
    push_frame(BANK, 0);
    push_frame(BANK, 0);
    chk("t4_bank_full", int'(bank_full), 3);
    chk("t4_s_ready", int'(s_ready), 0);
    rmode = 1;
    g = 0;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) break;
      g++;
      if (g > 2000) begin
        checks++;
        errors++;
        $display("FAIL t4_last_timeout t=%0t actual=no_m_last required=m_last", $time);
        break;
      end
    end
    @(posedge clk); #1;
    chk("t4_s_ready_after", int'(s_ready), 1);
    push_beat(rnd_data(), 1'b1);
    chk("t4_next_addr", int'(ram_wr_addr), 0);
    wait_drain();

    // flush mid-stream
    do_reset();
    rmode = 1;
    pop_cnt = 0;
    push_frame(BANK, 0);
    g = 0;
    forever begin
      @(negedge clk);
      if (pop_cnt >= 100) break;
      g++;
      if (g > 2000) begin
        checks++;
        errors++;
        $display("FAIL t5_stream_timeout t=%0t actual=%0d required=100", $time, pop_cnt);
        break;
      end
    end
    @(posedge clk); #1;
    buf_flush = 1'b1;
    @(posedge clk); #1;
    buf_flush = 1'b0;
    chk("t5_m_valid", int'(m_valid), 0);
    chk("t5_bank_full", int'(bank_full), 0);
    chk("t5_s_ready", int'(s_ready), 1);
    push_beat(rnd_data(), 1'b1);
    chk("t5_next_addr", int'(ram_wr_addr), 0);
    wait_drain();

    // reset mid-frame at beat 37, then a fresh 3-beat frame
    do_reset();
    for (int i = 0; i < 37; i++) push_beat(rnd_data(), 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_wr_en", int'(ram_wr_en), 0);
    chk("t6_wr_addr", int'(ram_wr_addr), 0);
    chk("t6_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    obs_len.delete();
    push_beat(rnd_data(), 1'b0);
    chk("t6_first_addr", int'(ram_wr_addr), 0);
    push_beat(rnd_data(), 1'b0);
    push_beat(rnd_data(), 1'b1);
    wait_drain();
    chk("t6_frame_len", (obs_len.size() > 0) ? obs_len[0] : -1, 3);

    // random frame lengths, gaps and backpressure
    do_reset();
    rmode = 3;
    for (int f = 0; f < 14; f++) push_frame($urandom_range(1, 300), 1);
    rmode = 1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
